// File: rtl/gps_capture_pkg.sv
// gps_capture_pkg: FSM states, register addresses and STATUS/CONTROL bit positions
package gps_capture_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_PUSH
    } state_t;

    localparam logic [1:0] ADDR_DATA      = 2'd0;
    localparam logic [1:0] ADDR_STATUS    = 2'd1;
    localparam logic [1:0] ADDR_CONTROL   = 2'd2;
    localparam logic [1:0] ADDR_TIMESTAMP = 2'd3;

    localparam int STAT_EMPTY  = 8;
    localparam int STAT_FULL   = 9;
    localparam int STAT_OVF    = 10;
    localparam int STAT_MISSED = 11;

    localparam int CTRL_ENABLE = 0;
    localparam int CTRL_IRQ_EN = 1;

endpackage

// File: rtl/gps_capture_fifo.sv
// gps_capture_fifo: synchronous show-ahead FIFO; a pop frees a full slot for a same-cycle push
module gps_capture_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_data,
    output logic [WIDTH-1:0]         o_head,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_empty,
    output logic                     o_full
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rd];
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    // storage write; contents need no reset because count marks validity
    always_ff @(posedge clk)
        if (w_do_push) r_mem[r_wr] <= i_data;

    // pointers wrap naturally at the power-of-two depth; count tracks occupancy
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wr <= r_wr + 1'b1;
            if (w_do_pop)  r_rd <= r_rd + 1'b1;
            if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
            else if (!w_do_push && w_do_pop) r_count <= r_count - 1'b1;
        end
    end

endmodule

// File: rtl/gps_capture_ctrl.sv
// gps_capture_ctrl: GPS parallel-word capture with settle filter, FIFO and Avalon-MM registers.
// Define GPS_CAPTURE_TIMESTAMP_EN to store a 32-bit cycle timestamp with each word (read at address 3).
module gps_capture_ctrl
    import gps_capture_pkg::*;
#(
    parameter int FIFO_DEPTH    = 4,
    parameter int STABLE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    input  logic [15:0] in_port,
    input  logic        in_strobe,
    output logic        irq
);
`ifdef GPS_CAPTURE_TIMESTAMP_EN
    localparam int FW = 48;
`else
    localparam int FW = 16;
`endif
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_t          r_state;
    state_t          w_next;
    logic [2:0]      r_sync;
    logic [15:0]     r_sample;
    logic [3:0]      r_cnt;
    logic [3:0]      w_cnt_next;
    logic            r_enable;
    logic            r_irq_en;
    logic            r_ovf;
    logic            r_missed;
    logic            r_irq;
    logic [31:0]     r_readdata;
    logic            w_edge;
    logic            w_push;
    logic            w_pop;
    logic            w_empty;
    logic            w_full;
    logic            w_ovf_clr;
    logic            w_mis_clr;
    logic [CW-1:0]   w_count;
    logic [FW-1:0]   w_head;
    logic [FW-1:0]   w_wdata;
    logic [31:0]     w_rdata;
    logic            w_unused_wdata;

    assign readdata       = r_readdata;
    assign irq            = r_irq;
    assign w_edge         = r_sync[1] & ~r_sync[2];
    assign w_push         = (r_state == ST_PUSH);
    assign w_pop          = read && (address == ADDR_DATA) && !w_empty;
    assign w_ovf_clr      = write && (address == ADDR_STATUS) && writedata[STAT_OVF];
    assign w_mis_clr      = write && (address == ADDR_STATUS) && writedata[STAT_MISSED];
    assign w_unused_wdata = ^{writedata[31:12], writedata[9:2]};

`ifdef GPS_CAPTURE_TIMESTAMP_EN
    logic [31:0] r_cycle;

    assign w_wdata = {r_cycle, r_sample};

    // free-running cycle counter stamped onto each pushed word
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) r_cycle <= '0;
        else          r_cycle <= r_cycle + 32'd1;
`else
    assign w_wdata = r_sample;
`endif

    gps_capture_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (FW)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_wdata),
        .o_head  (w_head),
        .o_count (w_count),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

    // two-flop strobe synchroniser plus one history flop for rising-edge detection
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) r_sync <= '0;
        else          r_sync <= {r_sync[1:0], in_strobe};

    // next state: settle until STABLE_CYCLES equal samples; disable forces IDLE
    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        case (r_state)
            ST_IDLE: begin
                w_cnt_next = '0;
                if (w_edge && r_enable) w_next = ST_SETTLE;
            end
            ST_SETTLE: begin
                w_cnt_next = (r_cnt != '0 && in_port == r_sample) ? r_cnt + 4'd1 : 4'd1;
                if (w_cnt_next == 4'(STABLE_CYCLES)) w_next = ST_PUSH;
            end
            default: w_next = ST_IDLE;
        endcase
        if (!r_enable) w_next = ST_IDLE;
    end

    // FSM state, settle counter and last in_port sample
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_sample <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            if (r_state == ST_SETTLE) r_sample <= in_port;
        end
    end

    // read mux; unselected bits and an empty FIFO read as zero
    always_comb begin
        w_rdata = '0;
        case (address)
            ADDR_DATA:    w_rdata[15:0] = w_empty ? 16'd0 : w_head[15:0];
            ADDR_STATUS: begin
                w_rdata[4:0]        = 5'(w_count);
                w_rdata[STAT_EMPTY]  = w_empty;
                w_rdata[STAT_FULL]   = w_full;
                w_rdata[STAT_OVF]    = r_ovf;
                w_rdata[STAT_MISSED] = r_missed;
            end
            ADDR_CONTROL: begin
                w_rdata[CTRL_ENABLE] = r_enable;
                w_rdata[CTRL_IRQ_EN] = r_irq_en;
            end
`ifdef GPS_CAPTURE_TIMESTAMP_EN
            ADDR_TIMESTAMP: w_rdata = w_empty ? 32'd0 : w_head[47:16];
`endif
            default: ;
        endcase
    end

    // control/status registers, registered read data and interrupt; sticky flags win over W1C
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_enable   <= 1'b0;
            r_irq_en   <= 1'b0;
            r_ovf      <= 1'b0;
            r_missed   <= 1'b0;
            r_readdata <= '0;
            r_irq      <= 1'b0;
        end else begin
            if (write && address == ADDR_CONTROL) begin
                r_enable <= writedata[CTRL_ENABLE];
                r_irq_en <= writedata[CTRL_IRQ_EN];
            end
            r_ovf    <= (w_push && w_full && !w_pop) | (r_ovf & ~w_ovf_clr);
            r_missed <= (w_edge && r_state != ST_IDLE) | (r_missed & ~w_mis_clr);
            if (read) r_readdata <= w_rdata;
            r_irq <= r_irq_en & (~w_empty | r_ovf);
        end
    end

endmodule

// File: doc/gps_capture_ctrl.md
GPS_CAPTURE_CTRL -- requirements
Module: gps_capture_ctrl

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, number of buffered GPS words (power of 2, 2..16).
REQ-002 SHALL have parameter STABLE_CYCLES, default 2, consecutive equal in_port samples required before capture (1..15).
REQ-003 SHALL have port clk, input, 1, system clock.
REQ-004 SHALL have port reset_n, input, 1, reset, asynchronous, active-low.
REQ-005 SHALL have port address, input, 2, Avalon-MM slave word address.
REQ-006 SHALL have ports read and write, input, 1 each, Avalon-MM strobes; zero wait states.
REQ-007 SHALL have port writedata, input, 32, Avalon-MM write data.
REQ-008 SHALL have port readdata, output, 32, registered Avalon-MM read data.
REQ-009 SHALL have port in_port, input, 16, GPS receiver parallel word, asynchronous to clk.
REQ-010 SHALL have port in_strobe, input, 1, GPS word-ready strobe, asynchronous to clk.
REQ-011 SHALL have port irq, output, 1, level interrupt.

Function
REQ-012 SHALL synchronise in_strobe through two flops and detect its rising edge on the synchronised signal.
REQ-013 SHALL run FSM IDLE -> SETTLE -> PUSH -> IDLE; IDLE leaves only on a strobe edge with CONTROL.enable=1.
REQ-014 SETTLE SHALL sample in_port each cycle, restart its counter on any change, and go to PUSH after STABLE_CYCLES consecutive equal samples.
REQ-015 PUSH SHALL write the settled word into the FIFO in one cycle, then return to IDLE; if the FIFO is full, SHALL drop the word and set STATUS.overflow.
REQ-016 Strobe edges arriving outside IDLE SHALL be ignored and SHALL set STATUS.missed.
REQ-017 Clearing CONTROL.enable SHALL force the FSM to IDLE next cycle; FIFO contents SHALL be kept.
REQ-018 Register map: 0 DATA (read pops head; bits 31:16 zero), 1 STATUS {count[4:0] at 4:0, empty 8, full 9, overflow 10, missed 11}, 2 CONTROL {enable 0, irq_en 1}, 3 TIMESTAMP.
REQ-019 readdata SHALL update on the cycle after read=1 (latency 1); unselected bits SHALL read 0.
REQ-020 A DATA read with the FIFO empty SHALL return 0 and SHALL NOT change any pointer.
REQ-021 A PUSH and a DATA pop in the same cycle SHALL both take effect, with count unchanged; when the FIFO is full, the pop SHALL free the slot and the push SHALL succeed.
REQ-022 A write of 1 to STATUS bit 10 or 11 SHALL clear that flag; set and clear in the same cycle SHALL leave the flag set.
REQ-023 irq SHALL equal irq_en AND (NOT empty OR overflow), registered.
REQ-024 FIFO pointers SHALL wrap modulo FIFO_DEPTH; count SHALL saturate at FIFO_DEPTH.

Reset
REQ-025 While reset_n=0, SHALL hold: readdata=0, irq=0, FSM=IDLE, FIFO empty, count=0, overflow=0, missed=0, enable=0, irq_en=0, synchroniser flops=0.
REQ-026 Reset asserted mid-SETTLE or mid-PUSH SHALL discard the word in progress.

Configuration
REQ-027 With GPS_CAPTURE_TIMESTAMP_EN defined: a free-running 32-bit cycle counter SHALL be stored alongside each word at PUSH, and address 3 SHALL return the head entry's timestamp without popping.
REQ-028 Without GPS_CAPTURE_TIMESTAMP_EN: no counter or timestamp storage SHALL exist, and address 3 SHALL read 0.

Structure
REQ-029 Shared package gps_capture_pkg SHALL hold the FSM state enum, register address constants and STATUS/CONTROL bit positions.
REQ-030 The FIFO SHALL be sub-module gps_capture_fifo (sync, FIFO_DEPTH x 16 or 48 bits, show-ahead head).

Verification
REQ-031 enable=1; in_port=16'h1234, strobe pulse -> after 2 sync + 2 settle + 1 push cycles count=1; DATA read returns 32'h00001234; empty=1.
REQ-032 in_port toggles 16'hAAAA/16'h5555 each cycle for 10 cycles, then holds 16'h0F0F -> captured word is 16'h0F0F.
REQ-033 5 strobes with no reads, FIFO_DEPTH=4 -> count=4, full=1, overflow=1, first four words kept; W1C to bit 10 -> overflow=0.
REQ-034 FIFO full and DATA read in the same cycle as PUSH -> count stays 4, no overflow, new word becomes the tail.
REQ-035 irq_en=1, one word captured -> irq=1; pop -> irq=0; DATA read on empty -> 0.
REQ-036 reset_n pulsed low during SETTLE -> count=0, all outputs 0; with TIMESTAMP_EN, two captures 100 cycles apart -> timestamp difference is 100.
